// File: rtl/cpu_pkg.sv
// Shared RV64I types: data word, instruction class, major opcodes and the decoded bundle.
package cpu_pkg;

  typedef logic [63:0] double_word;

  typedef enum logic [3:0] {
    OPC_ILLEGAL,
    OPC_LUI,
    OPC_AUIPC,
    OPC_JAL,
    OPC_JALR,
    OPC_BRANCH,
    OPC_LOAD,
    OPC_STORE,
    OPC_OP_IMM,
    OPC_OP_IMM_32,
    OPC_OP,
    OPC_OP_32,
    OPC_SYSTEM,
    OPC_FENCE
  } op_class_t;

  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPCODE_FENCE     = 7'b0001111;

  typedef struct packed {
    logic       valid;
    double_word pc;
    op_class_t  op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    double_word rs1_val;
    double_word rs2_val;
    double_word imm;
    logic       illegal;
  } decoded_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LUI:       return OPC_LUI;
      OPCODE_AUIPC:     return OPC_AUIPC;
      OPCODE_JAL:       return OPC_JAL;
      OPCODE_JALR:      return OPC_JALR;
      OPCODE_BRANCH:    return OPC_BRANCH;
      OPCODE_LOAD:      return OPC_LOAD;
      OPCODE_STORE:     return OPC_STORE;
      OPCODE_OP_IMM:    return OPC_OP_IMM;
      OPCODE_OP_IMM_32: return OPC_OP_IMM_32;
      OPCODE_OP:        return OPC_OP;
      OPCODE_OP_32:     return OPC_OP_32;
      OPCODE_SYSTEM:    return OPC_SYSTEM;
      OPCODE_FENCE:     return OPC_FENCE;
      default:          return OPC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; the opcode arrives already classified, so only bits 31:7 are needed.
import cpu_pkg::*;

module imm_gen (
  input  logic [31:7] instruction,
  input  op_class_t   op_class,
  output double_word  imm
);

  always_comb begin
    imm = '0;
    case (op_class)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
        imm = {{52{instruction[31]}}, instruction[31:20]};
      OPC_STORE:
        imm = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OPC_BRANCH:
        imm = {{51{instruction[31]}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{32{instruction[31]}}, instruction[31:12], 12'b0};
      OPC_JAL:
        imm = {{43{instruction[31]}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode.sv
// RV64I decode stage: classify, extract fields, detect load-use hazards, register one bundle per cycle.
import cpu_pkg::*;

module instruction_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  double_word  instruction_pc,
  input  logic        stall_in,
  output logic        stall_out,
  input  logic        branch_reset_in,
  output logic        branch_reset_out,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  double_word  rs1_data,
  input  double_word  rs2_data,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  output logic        out_valid,
  output double_word  out_pc,
  output op_class_t   out_op,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output double_word  out_rs1_val,
  output double_word  out_rs2_val,
  output double_word  out_imm,
  output logic        out_illegal
);

  op_class_t  op;
  logic       legal;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;
  logic [2:0] f3;
  logic [6:0] f7;
  double_word imm;
  decoded_t   dec;
  decoded_t   out_q;

  assign f3       = instruction[14:12];
  assign f7       = instruction[31:25];
  assign rs1_addr = instruction[19:15];
  assign rs2_addr = instruction[24:20];

  imm_gen u_imm_gen (
    .instruction (instruction[31:7]),
    .op_class    (op),
    .imm         (imm)
  );

  // Funct-level legality: base RV64I only (no M extension encodings in OP/OP_32).
  always_comb begin
    op    = classify(instruction[6:0]);
    legal = 1'b1;
    case (op)
      OPC_ILLEGAL: legal = 1'b0;
      OPC_JALR:    legal = (f3 == 3'd0);
      OPC_BRANCH:  legal = (f3[2:1] != 2'b01);
      OPC_LOAD:    legal = (f3 != 3'd7);
      OPC_STORE:   legal = !f3[2];
      OPC_OP_IMM: begin
        if (f3 == 3'd1)      legal = (f7[6:1] == 6'b000000);
        else if (f3 == 3'd5) legal = (f7[6:1] == 6'b000000) || (f7[6:1] == 6'b010000);
      end
      OPC_OP_IMM_32: begin
        case (f3)
          3'd0:    legal = 1'b1;
          3'd1:    legal = (f7 == 7'h00);
          3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b0;
        endcase
      end
      OPC_OP:      legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      OPC_OP_32:   legal = ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5)) &&
                           ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 != 3'd1)));
      OPC_SYSTEM:  legal = (f3 == 3'd0) ? ((instruction == 32'h0000_0073) || (instruction == 32'h0010_0073))
                                        : (f3 != 3'd4);
      OPC_FENCE:   legal = (f3[2:1] == 2'b00);
      default:     legal = 1'b1;
    endcase
  end

  assign rs1_used = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_ILLEGAL});
  assign rs2_used = op inside {OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP_32};

  assign hazard = in_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  (((ex_rd == rs1_addr) && rs1_used) || ((ex_rd == rs2_addr) && rs2_used));
  assign stall_out = stall_in || hazard;

  always_comb begin
    dec         = '0;
    dec.valid   = in_valid;
    dec.pc      = instruction_pc;
    dec.op      = op;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rd      = instruction[11:7];
    dec.rs1     = rs1_addr;
    dec.rs2     = rs2_addr;
    dec.rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    dec.rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
    dec.imm     = imm;
    dec.illegal = in_valid && !legal;
  end

  // Priority: reset/flush, then hold, then bubble, then load.
  always_ff @(posedge clk) begin
    branch_reset_out <= rst ? 1'b0 : branch_reset_in;
    if (rst || branch_reset_in) begin
      out_q.valid   <= 1'b0;
      out_q.illegal <= 1'b0;
    end else if (!stall_in) begin
      if (hazard) begin
        out_q.valid   <= 1'b0;
        out_q.illegal <= 1'b0;
      end else begin
        out_q <= dec;
      end
    end
  end

  assign out_valid   = out_q.valid;
  assign out_pc      = out_q.pc;
  assign out_op      = out_q.op;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode with hand-computed expectations.
import cpu_pkg::*;

module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  double_word  instruction_pc;
  logic        stall_in;
  logic        stall_out;
  logic        branch_reset_in;
  logic        branch_reset_out;
  logic [4:0]  rs1_addr, rs2_addr;
  double_word  rs1_data, rs2_data;
  logic        ex_valid, ex_is_load;
  logic [4:0]  ex_rd;
  logic        out_valid;
  double_word  out_pc;
  op_class_t   out_op;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  double_word  out_rs1_val, out_rs2_val, out_imm;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .stall_in         (stall_in),
    .stall_out        (stall_out),
    .branch_reset_in  (branch_reset_in),
    .branch_reset_out (branch_reset_out),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .out_valid        (out_valid),
    .out_pc           (out_pc),
    .out_op           (out_op),
    .out_funct3       (out_funct3),
    .out_funct7       (out_funct7),
    .out_rd           (out_rd),
    .out_rs1          (out_rs1),
    .out_rs2          (out_rs2),
    .out_rs1_val      (out_rs1_val),
    .out_rs2_val      (out_rs2_val),
    .out_imm          (out_imm),
    .out_illegal      (out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tab_inst [6];
  op_class_t   tab_op   [6];
  double_word  tab_imm  [6];
  logic        tab_ill  [6];

  initial begin
    tab_inst[0] = 32'h800F_F06F; tab_op[0] = OPC_JAL;     tab_imm[0] = 64'hFFFF_FFFF_FFFF_F000; tab_ill[0] = 1'b0;
    tab_inst[1] = 32'hFE00_0EE3; tab_op[1] = OPC_BRANCH;  tab_imm[1] = 64'hFFFF_FFFF_FFFF_FFFC; tab_ill[1] = 1'b0;
    tab_inst[2] = 32'hFE20_BC23; tab_op[2] = OPC_STORE;   tab_imm[2] = 64'hFFFF_FFFF_FFFF_FFF8; tab_ill[2] = 1'b0;
    tab_inst[3] = 32'h8000_00B7; tab_op[3] = OPC_LUI;     tab_imm[3] = 64'hFFFF_FFFF_8000_0000; tab_ill[3] = 1'b0;
    tab_inst[4] = 32'h0200_0033; tab_op[4] = OPC_OP;      tab_imm[4] = 64'h0;                   tab_ill[4] = 1'b1;
    tab_inst[5] = 32'h0000_007F; tab_op[5] = OPC_ILLEGAL; tab_imm[5] = 64'h0;                   tab_ill[5] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; instruction = 32'h0; instruction_pc = '0;
    stall_in = 1'b0; branch_reset_in = 1'b0; rs1_data = '0; rs2_data = '0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_brout", 64'(branch_reset_out), 64'd0);
    rst = 1'b0;

    // ADDI x5,x0,-1 with junk on rs1_data: x0 read must be forced to zero
    in_valid = 1'b1; instruction = 32'hFFF0_0293; instruction_pc = 64'h1000;
    rs1_data = 64'hDEAD; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd31;
    #1;
    check("addi_rs1_addr", 64'(rs1_addr), 64'd0);
    check("addi_rs2_addr", 64'(rs2_addr), 64'd31);
    check("addi_rs2_unused_nostall", 64'(stall_out), 64'd0);
    tick();
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_op", 64'(out_op), 64'(OPC_OP_IMM));
    check("addi_rd", 64'(out_rd), 64'd5);
    check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_pc", out_pc, 64'h1000);
    check("addi_rs1_val_x0", out_rs1_val, 64'd0);
    check("addi_illegal", 64'(out_illegal), 64'd0);

    // ADD x6,x5,x7 behind a load to x5
    instruction = 32'h0072_8333; instruction_pc = 64'h1004; ex_rd = 5'd5;
    rs1_data = 64'h11; rs2_data = 64'h22;
    #1;
    check("hazard_stall", 64'(stall_out), 64'd1);
    tick();
    check("hazard_bubble", 64'(out_valid), 64'd0);
    ex_valid = 1'b0;
    #1;
    check("hazard_clear", 64'(stall_out), 64'd0);
    tick();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_op", 64'(out_op), 64'(OPC_OP));
    check("add_rd", 64'(out_rd), 64'd6);
    check("add_rs1_val", out_rs1_val, 64'h11);
    check("add_rs2_val", out_rs2_val, 64'h22);
    check("add_imm", out_imm, 64'd0);
    check("add_pc", out_pc, 64'h1004);

    // Load to x0 never hazards: stall_out follows stall_in
    instruction = 32'h0000_0333; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
    #1;
    check("x0_nohazard", 64'(stall_out), 64'd0);
    stall_in = 1'b1;
    #1;
    check("x0_stall_in", 64'(stall_out), 64'd1);
    stall_in = 1'b0; ex_valid = 1'b0;

    // BEQ x1,x2,+8 held for three cycles while the input changes
    instruction = 32'h0020_8463; instruction_pc = 64'h2000;
    tick();
    check("beq_op", 64'(out_op), 64'(OPC_BRANCH));
    check("beq_imm", out_imm, 64'd8);
    stall_in = 1'b1; instruction = 32'hFFF0_0293; instruction_pc = 64'h3000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_op", 64'(out_op), 64'(OPC_BRANCH));
      check("hold_imm", out_imm, 64'd8);
      check("hold_pc", out_pc, 64'h2000);
      check("hold_rs2", 64'(out_rs2), 64'd2);
    end

    // Flush beats stall
    branch_reset_in = 1'b1;
    tick();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_brout", 64'(branch_reset_out), 64'd1);
    branch_reset_in = 1'b0; stall_in = 1'b0;
    tick();
    check("flush_brout_clear", 64'(branch_reset_out), 64'd0);

    // Immediate formats and illegal encodings
    for (int i = 0; i < 6; i++) begin
      instruction = tab_inst[i]; instruction_pc = 64'h4000 + 64'(i * 4);
      tick();
      check("tab_valid", 64'(out_valid), 64'd1);
      check("tab_op", 64'(out_op), 64'(tab_op[i]));
      check("tab_imm", out_imm, tab_imm[i]);
      check("tab_illegal", 64'(out_illegal), 64'(tab_ill[i]));
    end
    check("sd_funct3", 64'(out_funct3), 64'd0);
    in_valid = 1'b0;
    tick();
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_illegal", 64'(out_illegal), 64'd0);

    // Reset while stalled discards the held bundle
    in_valid = 1'b1; instruction = 32'hFE20_BC23; instruction_pc = 64'h5000;
    tick();
    check("sd_funct3_loaded", 64'(out_funct3), 64'd3);
    stall_in = 1'b1; rst = 1'b1;
    tick();
    check("rst_stall_valid", 64'(out_valid), 64'd0);
    rst = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have no parameters; XLEN fixed at 64 via the shared package type double_word.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  fetch stage holds a valid instruction.
REQ-005 instruction  input  32  raw RV64I instruction word.
REQ-006 instruction_pc  input  64  PC of instruction.
REQ-007 stall_in  input  1  downstream (execute) cannot accept; hold output register.
REQ-008 stall_out  output  1  to fetch/PC: freeze fetch register and PC this cycle.
REQ-009 branch_reset_in  input  1  flush request, from the pipeline's branch-reset chain.
REQ-010 branch_reset_out  output  1  flush forwarded downstream, registered.
REQ-011 rs1_addr, rs2_addr  output  5 each  register-file read addresses, combinational from instruction.
REQ-012 rs1_data, rs2_data  input  64 each  register-file read data, same cycle.
REQ-013 ex_valid, ex_is_load  input  1 each  instruction currently in execute is valid / is a load.
REQ-014 ex_rd  input  5  destination of the instruction in execute.
REQ-015 out_valid  output  1  decoded bundle valid.
REQ-016 out_pc  output  64; out_op  output  op_class_t; out_funct3  output  3; out_funct7  output  7.
REQ-017 out_rd, out_rs1, out_rs2  output  5 each; out_rs1_val, out_rs2_val  output  64 each; out_imm  output  64.
REQ-018 out_illegal  output  1  opcode/funct combination not in RV64I.

Function
REQ-019 Decode: op_class from opcode[6:0] among LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_IMM_32, OP, OP_32, SYSTEM, FENCE; any other opcode -> op_class ILLEGAL, out_illegal=1.
REQ-020 Immediate: I/S/B/U/J formats sign-extended from bit 31 to 64 bits; R-type imm=0; B and J immediates have bit0=0.
REQ-021 rs1_addr=instruction[19:15], rs2_addr=instruction[24:20] always, independent of stall and valid.
REQ-022 Load-use hazard = in_valid && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used); rs2 used only for BRANCH, STORE, OP, OP_32.
REQ-023 stall_out = stall_in || hazard; combinational.
REQ-024 Output register update priority per cycle: flush > hold > bubble > load.
REQ-025 Flush: branch_reset_in=1 -> out_valid<=0 next cycle, regardless of stall_in.
REQ-026 Hold: stall_in=1 (no flush) -> all out_* unchanged.
REQ-027 Bubble: hazard=1, stall_in=0 -> out_valid<=0; fetch retains instruction; reissues next cycle.
REQ-028 Load: otherwise out_valid<=in_valid and all out_* <= decoded fields; latency one cycle.
REQ-029 Operand values forwarded as read (rs1_data/rs2_data); x0 reads forced to 0 regardless of rs*_data.
REQ-030 branch_reset_out <= branch_reset_in every cycle, independent of stall.
REQ-031 Field outputs when out_valid=0 are don't-care except out_illegal, which SHALL be 0.

Reset
REQ-032 rst=1 -> out_valid=0, out_illegal=0, branch_reset_out=0 next edge; other out_* don't-care.
REQ-033 rst during a hazard or stall discards the held instruction; no bundle emitted after rst until a new in_valid.

Structure
REQ-034 cpu_pkg SHALL hold double_word, op_class_t enum, opcode localparams and decoded-bundle struct.
REQ-035 Immediate extraction SHALL be one combinational sub-module imm_gen (instruction, op_class -> 64-bit imm).
REQ-036 Decoder, hazard detection, output register in instruction_decode; no register file inside.

Verification
REQ-037 ADDI x5,x0,-1 (0xFFF00293) valid, no stall -> next cycle out_op=OP_IMM, rd=5, imm=0xFFFF_FFFF_FFFF_FFFF, out_valid=1.
REQ-038 ex_is_load, ex_rd=5, in ADD x6,x5,x7 -> stall_out=1, out_valid=0 next; ex_valid dropped -> ADD issued one cycle later.
REQ-039 ex_rd=0 load, instruction reads x0 -> no hazard, stall_out=stall_in.
REQ-040 stall_in=1 for 3 cycles holding a BEQ bundle -> outputs bit-identical over the 3 cycles.
REQ-041 branch_reset_in=1 with stall_in=1 -> out_valid=0 next cycle, branch_reset_out=1 next cycle.
REQ-042 opcode 0x7F -> out_illegal=1, out_valid=1; JAL imm 0x800FF06F-class cases check sign extension and bit0=0.
